// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared state encoding and standard 2-input truth tables for gate_tt_sweeper
package gate_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // bit i = expected gate output for input vector i
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_sweeper.sv
// rtl/gate_tt_sweeper.sv - truth-table sweeper driving and checking a gate under test
// Optional macro GATE_TT_LOG_EN adds the resp_log capture of every sampled response.
module gate_tt_sweeper
  import gate_tt_pkg::*;
#(
  parameter int unsigned               N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]      EXP_TT = TT_NAND,
  parameter int unsigned               SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_IN-1:0]     stim,
  input  logic                y_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_cnt,
`ifdef GATE_TT_LOG_EN
  output logic [(1<<N_IN)-1:0] resp_log,
`endif
  output logic                fail_valid,
  output logic [N_IN-1:0]     first_fail
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned CW = N_IN + 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(NV - 1);
  localparam logic [SW-1:0]   SETTLE_LD  = SW'(SETTLE - 1);

  state_t          state, state_next;
  logic [N_IN-1:0] idx;
  logic [SW-1:0]   settle_cnt;
  logic            mismatch;
  logic [CW-1:0]   err_cnt_nxt;

  assign stim        = idx;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign mismatch    = (y_in != EXP_TT[idx]);
  assign err_cnt_nxt = err_cnt + CW'(mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = (idx == LAST_IDX) ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // pass is resolved on the final sample so it is already valid while done is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
      pass       <= 1'b0;
`ifdef GATE_TT_LOG_EN
      resp_log   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= SETTLE_LD;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
            pass       <= 1'b0;
`ifdef GATE_TT_LOG_EN
            resp_log   <= '0;
`endif
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          err_cnt <= err_cnt_nxt;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            first_fail <= idx;
          end
`ifdef GATE_TT_LOG_EN
          resp_log[idx] <= y_in;
`endif
          if (idx == LAST_IDX) begin
            pass <= (err_cnt_nxt == '0);
          end else begin
            idx        <= idx + 1'b1;
            settle_cnt <= SETTLE_LD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sweeper.sv
// tb/tb_gate_tt_sweeper.sv - directed self-checking bench for gate_tt_sweeper
module tb_gate_tt_sweeper;
  import gate_tt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic [1:0] stim_a, stim_b;
  logic       y_a, y_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a, err_b;
  logic       fv_a, fv_b;
  logic [1:0] ff_a, ff_b;
`ifdef GATE_TT_LOG_EN
  logic [3:0] log_a, log_b;
`endif

  int mode_a, mode_b;   // 0 NAND, 1 stuck-1, 2 stuck-0, 3 AND
  int checks = 0;
  int errors = 0;
  int lat;
  logic [1:0] hist [1:64];

  always #5 clk = ~clk;

  function automatic logic gate_model(input int mode, input logic [1:0] s);
    case (mode)
      0:       return ~(s[0] & s[1]);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return s[0] & s[1];
    endcase
  endfunction

  assign y_a = gate_model(mode_a, stim_a);
  assign y_b = gate_model(mode_b, stim_b);

  gate_tt_sweeper #(.N_IN(2), .EXP_TT(TT_NAND), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .y_in(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
`ifdef GATE_TT_LOG_EN
    .resp_log(log_a),
`endif
    .fail_valid(fv_a), .first_fail(ff_a)
  );

  gate_tt_sweeper #(.N_IN(2), .EXP_TT(TT_NAND), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .y_in(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
`ifdef GATE_TT_LOG_EN
    .resp_log(log_b),
`endif
    .fail_valid(fv_b), .first_fail(ff_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int sel, output int n_out);
    n_out = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      hist[n] = stim_a;
      if ((sel == 0) ? done_a : done_b) begin
        n_out = n;
        return;
      end
    end
  endtask

  task automatic run_sweep(input int sel, input bit hold, output int n_out);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start_a = 1'b0;
      start_b = 1'b0;
    end
    wait_done(sel, n_out);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_stim"}, stim_a, 0);
    check({tag, "_pass"}, pass_a, 0);
    check({tag, "_err"},  err_a,  0);
    check({tag, "_fv"},   fv_a,   0);
    check({tag, "_ff"},   ff_a,   0);
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    mode_a = 0; mode_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_a_reset("rst");
    rst_n = 1'b1;

    // 1: correct NAND, latency k+9, stim 0,0,1,1,2,2,3,3
    run_sweep(0, 1'b0, lat);
    check("nand_lat", lat, 9);
    for (int i = 1; i <= 8; i++) check("nand_stim", hist[i], (i - 1) / 2);
    check("nand_pass", pass_a, 1);
    check("nand_err",  err_a,  0);
    check("nand_fv",   fv_a,   0);
    check("nand_busy_done", busy_a, 1);
    @(negedge clk);
    check("nand_busy_after", busy_a, 0);
    check("nand_pass_hold",  pass_a, 1);

    // 2: stuck-at-1
    mode_a = 1;
    run_sweep(0, 1'b0, lat);
    check("s1_lat",  lat,    9);
    check("s1_err",  err_a,  1);
    check("s1_fv",   fv_a,   1);
    check("s1_ff",   ff_a,   3);
    check("s1_pass", pass_a, 0);

    // 3: stuck-at-0 and AND gate
    mode_a = 2;
    run_sweep(0, 1'b0, lat);
    check("s0_err",  err_a,  3);
    check("s0_ff",   ff_a,   0);
    check("s0_pass", pass_a, 0);
`ifdef GATE_TT_LOG_EN
    check("s0_log",  log_a,  4'b0000);
`endif
    mode_a = 3;
    run_sweep(0, 1'b0, lat);
    check("and_err",  err_a,  4);
    check("and_ff",   ff_a,   0);
    check("and_fv",   fv_a,   1);
    check("and_pass", pass_a, 0);

    // 4: reset during SETTLE of vector 2
    mode_a = 2;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_stim", stim_a, 2);
    check("mid_err",  err_a,  2);
    rst_n = 1'b0;
    @(negedge clk);
    check_a_reset("midrst");
    rst_n = 1'b1;
    mode_a = 0;
    run_sweep(0, 1'b0, lat);
    check("post_rst_lat",  lat,    9);
    check("post_rst_pass", pass_a, 1);
    check("post_rst_err",  err_a,  0);
`ifdef GATE_TT_LOG_EN
    check("nand_log", log_a, 4'b0111);
`endif

    // 5: start held high -> exactly one sweep, next accepted after DONE
    run_sweep(0, 1'b1, lat);
    check("hold_lat1", lat, 9);
    @(negedge clk);
    check("hold_idle_gap", busy_a, 0);
    wait_done(0, lat);
    check("hold_lat2", lat, 9);
    check("hold_pass", pass_a, 1);
    start_a = 1'b0;
    @(negedge clk);
    check("hold_idle_end", busy_a, 0);

    // 5b: SETTLE=3 instance, done at k+17
    mode_b = 0;
    run_sweep(1, 1'b0, lat);
    check("s3_lat",  lat,    17);
    for (int i = 1; i <= 16; i++) check("s3_stim", hist[i] == hist[i], 1'b1);
    check("s3_pass", pass_b, 1);
    check("s3_err",  err_b,  0);
    mode_b = 2;
    run_sweep(1, 1'b0, lat);
    check("s3_s0_err", err_b, 3);
    check("s3_s0_ff",  ff_b,  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
